// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter feeding the display path.
// One conversion in flight; result and overflow flag are held until the next DONE.
module bin_to_bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint               MAX_DEC  = pow10(DIGITS) - 1;
  localparam logic [BIN_W-1:0]     MAX_BIN  = MAX_DEC[BIN_W-1:0];
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BIN_W - 1);

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] a;
    a = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[BIN_W + 4*d +: 4] >= 4'd5)
        a[BIN_W + 4*d +: 4] = a[BIN_W + 4*d +: 4] + 4'd3;
    end
    return {a[SCR_W-2:0], 1'b0};
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [SCR_W-1:0]   scratch_q,   scratch_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               ovf_pend_q,  ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q,       bcd_d;
  logic               ovf_q,       ovf_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic               accept;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;
  assign bcd_valid = bcd_valid_q;

  always_comb begin
    state_d     = state_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    bcd_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Out-of-range inputs skip the shift phase entirely.
          if (bin_in > MAX_BIN) begin
            ovf_pend_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            scratch_d  = {{BCD_W{1'b0}}, bin_in};
            cnt_d      = '0;
            ovf_pend_d = 1'b0;
            state_d    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        scratch_d = dabble_step(scratch_q);
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d       = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q[SCR_W-1 -: BCD_W];
        ovf_d       = ovf_pend_q;
        bcd_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

endmodule
